// File: rtl/pll_clken_gen.sv
// Multi-channel clock-enable generator: NUM_CH aligned strobes with programmable divide/phase and a lock flag.
// Optional macro PLL_CLKEN_DUTY_EN adds a registered near-50% duty level per channel on outclk_lvl.
module pll_clken_gen #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DIV_RST     = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] outclk_en,
    output logic [NUM_CH-1:0] outclk_lvl,
    output logic              locked
);

    localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);
    localparam logic [CH_W:0]    NUM_CH_C    = (CH_W + 1)'(NUM_CH);
    localparam logic [DIV_W-1:0] DIV_RST_C   = (DIV_RST < 1) ? DIV_W'(1) : DIV_W'(DIV_RST);

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic              locked_q, locked_d;
    logic [DIV_W-1:0]  div_q   [NUM_CH];
    logic [DIV_W-1:0]  div_d   [NUM_CH];
    logic [DIV_W-1:0]  phase_q [NUM_CH];
    logic [DIV_W-1:0]  phase_d [NUM_CH];
    logic [DIV_W-1:0]  cnt_q   [NUM_CH];
    logic [DIV_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic              cfg_hit_s;
    logic [DIV_W-1:0]  wr_div_s;
    logic [DIV_W-1:0]  wr_phase_s;

`ifdef PLL_CLKEN_DUTY_EN
    logic [NUM_CH-1:0] lvl_q, lvl_d;

    // High for the first ceil(D/2) cycles of each period, measured from the strobe.
    function automatic logic duty_high(input logic [DIV_W-1:0] cnt,
                                       input logic [DIV_W-1:0] ph,
                                       input logic [DIV_W-1:0] div);
        logic [DIV_W-1:0] off;
        logic [DIV_W:0]   half;
        off  = (cnt >= ph) ? (cnt - ph) : (cnt + div - ph);
        half = ({1'b0, div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
        return ({1'b0, off} < half);
    endfunction
`endif

    // Lock FSM next state: any accepted write restarts settling.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        cfg_hit_s  = cfg_wr && ({1'b0, cfg_ch} < NUM_CH_C);
        wr_div_s   = (cfg_div == DIV_W'(0)) ? DIV_W'(1) : cfg_div;
        wr_phase_s = (cfg_phase >= wr_div_s) ? (wr_div_s - DIV_W'(1)) : cfg_phase;
        if (cfg_hit_s) begin
            state_d  = SETTLE;
            settle_d = SET_W'(0);
        end else begin
            case (state_q)
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d  = RUN;
                        settle_d = SET_W'(0);
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                RUN: begin
                    state_d  = RUN;
                    settle_d = SET_W'(0);
                end
                default: begin
                    state_d  = SETTLE;
                    settle_d = SET_W'(0);
                end
            endcase
        end
        locked_d = (state_d == RUN);
    end

    // Per-channel config, phase counters and next-cycle output values.
    always_comb begin
        en_d = {NUM_CH{1'b0}};
`ifdef PLL_CLKEN_DUTY_EN
        lvl_d = {NUM_CH{1'b0}};
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]   = div_q[i];
            phase_d[i] = phase_q[i];
            cnt_d[i]   = DIV_W'(0);
            if (cfg_hit_s && (cfg_ch == CH_W'(i))) begin
                div_d[i]   = wr_div_s;
                phase_d[i] = wr_phase_s;
            end else begin
                div_d[i]   = div_q[i];
                phase_d[i] = phase_q[i];
            end
            // Counters only advance across two consecutive RUN cycles, so k=0 lands on the lock cycle.
            if ((state_q == RUN) && (state_d == RUN)) begin
                cnt_d[i] = (cnt_q[i] >= (div_q[i] - DIV_W'(1))) ? DIV_W'(0) : (cnt_q[i] + DIV_W'(1));
            end else begin
                cnt_d[i] = DIV_W'(0);
            end
            en_d[i] = locked_d && (cnt_d[i] == phase_d[i]);
`ifdef PLL_CLKEN_DUTY_EN
            lvl_d[i] = locked_d && duty_high(cnt_d[i], phase_d[i], div_d[i]);
`endif
        end
    end

    // State, config and output registers with synchronous reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= SETTLE;
            settle_q <= SET_W'(0);
            locked_q <= 1'b0;
            en_q     <= {NUM_CH{1'b0}};
`ifdef PLL_CLKEN_DUTY_EN
            lvl_q    <= {NUM_CH{1'b0}};
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= DIV_RST_C;
                phase_q[i] <= DIV_W'(0);
                cnt_q[i]   <= DIV_W'(0);
            end
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            locked_q <= locked_d;
            en_q     <= en_d;
`ifdef PLL_CLKEN_DUTY_EN
            lvl_q    <= lvl_d;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= div_d[i];
                phase_q[i] <= phase_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign outclk_en = en_q;
    assign locked    = locked_q;
`ifdef PLL_CLKEN_DUTY_EN
    assign outclk_lvl = lvl_q;
`else
    assign outclk_lvl = {NUM_CH{1'b0}};
`endif

endmodule
